// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the PC, issues in-order word fetches over a
// valid/ready request channel, buffers returned words with their PCs in a
// small FIFO and hands them to decode. Redirects flush the buffer and mark
// in-flight responses as stale so they are discarded on return.
module fetch_stage #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // instruction memory request channel
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  // instruction memory response channel (in order, no backpressure)
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  // branch/jump resolution
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  // decode handshake
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [31:0]     id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_pc4_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // architectural fetch state
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rsp_pc_q;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   drop_q;

  // instruction buffer
  logic [31:0]     instr_q [FIFO_DEPTH];
  logic [XLEN-1:0] ipc_q   [FIFO_DEPTH];
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [CW-1:0]   count_q;

  // per-cycle control
  logic            pop;
  logic            req_fire;
  logic            rsp_live;
  logic            rsp_stale;
  logic            push;
  logic [CW:0]     in_use;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   count_nxt;
  logic [CW-1:0]   drop_redirect;
  logic [XLEN-1:0] redirect_base;
  logic            unused_redirect_lsbs;

  assign redirect_base        = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // decode side: registered head entry, NOP pattern when empty
  assign id_valid_o = (count_q != '0) & ~redirect_i;
  assign id_instr_o = (count_q != '0) ? instr_q[head_q] : NOP;
  assign id_pc_o    = (count_q != '0) ? ipc_q[head_q]   : '0;
  assign id_pc4_o   = id_pc_o + PC_STEP;

  assign pop = id_valid_o & id_ready_i;

  // Credits: every outstanding request plus every buffered word owns a slot,
  // so a live response can always be pushed without a full check.
  assign in_use           = {1'b0, outstanding_q} + {1'b0, count_q} - {{CW{1'b0}}, pop};
  assign imem_req_valid_o = ~rst_i & ~redirect_i & (in_use < DEPTH_W);
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = imem_req_valid_o & imem_req_ready_i;

  // A response is live only if nothing stale is ahead of it and it matches
  // a request we actually issued; anything else is dropped or ignored.
  assign rsp_live  = imem_rsp_valid_i & (drop_q == '0) & (outstanding_q != '0);
  assign rsp_stale = imem_rsp_valid_i & (drop_q != '0);
  assign push      = rsp_live & ~rst_i & ~redirect_i;

  // next-value arithmetic for counters
  always_comb begin
    outstanding_nxt = outstanding_q;
    if (req_fire && !rsp_live) begin
      outstanding_nxt = outstanding_q + CW'(1);
    end else if (!req_fire && rsp_live) begin
      outstanding_nxt = outstanding_q - CW'(1);
    end

    count_nxt = count_q;
    if (rsp_live && !pop) begin
      count_nxt = count_q + CW'(1);
    end else if (!rsp_live && pop) begin
      count_nxt = count_q - CW'(1);
    end

    // everything in flight becomes stale; a response arriving right now is
    // consumed this cycle, so it is not counted again
    drop_redirect = drop_q + outstanding_q;
    if (imem_rsp_valid_i && (drop_redirect != '0)) begin
      drop_redirect = drop_redirect - CW'(1);
    end
  end

  // control state: reset, then redirect, then normal fetch/return/pop
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else if (redirect_i) begin
      pc_q          <= redirect_base;
      rsp_pc_q      <= redirect_base;
      outstanding_q <= '0;
      drop_q        <= drop_redirect;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      if (req_fire) begin
        pc_q <= pc_q + PC_STEP;
      end
      if (rsp_live) begin
        rsp_pc_q <= rsp_pc_q + PC_STEP;
        tail_q   <= tail_q + PW'(1);
      end
      if (rsp_stale) begin
        drop_q <= drop_q - CW'(1);
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      outstanding_q <= outstanding_nxt;
      count_q       <= count_nxt;
    end
  end

  // buffer storage: written at the tail on each live response
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_q[tail_q] <= imem_rsp_data_i[31:0];
      ipc_q[tail_q]   <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a fixed-latency instruction memory model.
module tb_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc4_o;

  always #5 clk_i = ~clk_i;

  fetch_stage #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .imem_req_valid_o(imem_req_valid_o),
    .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .id_valid_o(id_valid_o),
    .id_ready_i(id_ready_i),
    .id_instr_o(id_instr_o),
    .id_pc_o(id_pc_o),
    .id_pc4_o(id_pc4_o)
  );

  int checks = 0;
  int errors = 0;
  int lat = 1;
  logic        pv [4];
  logic [31:0] pa [4];

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        chk_en;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_idv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [24];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1357_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_req(input string tag, input logic exp_v, input logic [31:0] exp_addr);
    chk({tag, ".req_valid"}, 32'(imem_req_valid_o), 32'(exp_v));
    if (exp_v) chk({tag, ".req_addr"}, imem_req_addr_o, exp_addr);
  endtask

  task automatic check_id(input string tag, input logic exp_v, input logic [31:0] exp_pc);
    logic [31:0] pc;
    pc = exp_v ? exp_pc : 32'h0;
    chk({tag, ".id_valid"}, 32'(id_valid_o), 32'(exp_v));
    chk({tag, ".id_pc"}, id_pc_o, pc);
    chk({tag, ".id_pc4"}, id_pc4_o, pc + 32'd4);
    chk({tag, ".id_instr"}, id_instr_o, exp_v ? mem_word(pc) : 32'h0000_0013);
  endtask

  // one clock: capture the handshake, advance the memory pipe, apply inputs
  task automatic tick(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
    logic        fire;
    logic [31:0] a;
    fire = imem_req_valid_o & imem_req_ready_i;
    a    = imem_req_addr_o;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 3; i++) begin
      pv[i] = pv[i+1];
      pa[i] = pa[i+1];
    end
    pv[3] = 1'b0;
    pa[3] = '0;
    if (fire) begin
      pv[lat-1] = 1'b1;
      pa[lat-1] = a;
    end
    imem_rsp_valid_i = pv[0];
    imem_rsp_data_i  = pv[0] ? mem_word(pa[0]) : 32'hDEAD_BEEF;
    rst_i         = r;
    id_ready_i    = rdy;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    #1;
  endtask

  task automatic do_reset(input int n);
    repeat (n) tick(1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  // bounded wait for the next delivered instruction; returns cycles taken
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!id_valid_o && n < 20) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      n++;
    end
    if (n >= 20) begin
      errors++;
      $display("FAIL %s.timeout: actual=no id_valid expected=id_valid within 20 cycles", tag);
    end
  endtask

  initial begin
    int n;
    rst_i = 1'b1;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i = '0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    id_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
    end

    // reset, streaming, then stall/release with a 1-cycle memory
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    for (int i = 13; i <= 20; i++) vecs[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h08, 1'b1, 32'h0};
    vecs[21] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
    vecs[22] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
    vecs[23] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};

    lat = 1;
    for (int i = 0; i < 24; i++) begin
      tick(vecs[i].rst, vecs[i].rdy, 1'b0, 32'h0);
      if (vecs[i].chk_en) begin
        check_req($sformatf("row%0d", i), vecs[i].exp_req, vecs[i].exp_addr);
        check_id($sformatf("row%0d", i), vecs[i].exp_idv, vecs[i].exp_pc);
      end
    end

    // redirect to 0x103 with two requests outstanding, 2-cycle memory
    lat = 2;
    do_reset(3);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    check_req("rd4.c0", 1'b1, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    check_req("rd4.c1", 1'b1, 32'h4);
    tick(1'b0, 1'b1, 1'b1, 32'h0000_0103);
    check_req("rd4.redir", 1'b0, 32'h0);
    check_id("rd4.redir", 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    check_req("rd4.after", 1'b1, 32'h100);
    check_id("rd4.after", 1'b0, 32'h0);
    wait_valid("rd4", n);
    chk("rd4.latency", 32'(n), 32'd3);
    check_id("rd4.first", 1'b1, 32'h100);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    check_id("rd4.second", 1'b1, 32'h104);

    // redirect to the top of the address space while a word is buffered
    lat = 1;
    do_reset(2);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    check_id("rd5.pre", 1'b1, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("rd5.redir.id_valid", 32'(id_valid_o), 32'd0);
    check_req("rd5.redir", 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    check_req("rd5.c1", 1'b1, 32'hFFFF_FFFC);
    check_id("rd5.c1", 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    check_req("rd5.c2", 1'b1, 32'h0000_0000);
    check_id("rd5.c2", 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    check_id("rd5.c3", 1'b1, 32'hFFFF_FFFC);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    check_id("rd5.c4", 1'b1, 32'h0000_0000);

    // reset with two requests to 0x200/0x204 in flight
    lat = 2;
    do_reset(3);
    tick(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    check_req("rs6.redir", 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    check_req("rs6.c1", 1'b1, 32'h200);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    check_req("rs6.c2", 1'b1, 32'h204);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    check_req("rs6.rst", 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    check_req("rs6.rel", 1'b1, 32'h0);
    check_id("rs6.rel", 1'b0, 32'h0);
    wait_valid("rs6", n);
    chk("rs6.latency", 32'(n), 32'd3);
    check_id("rs6.first", 1'b1, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    check_id("rs6.second", 1'b1, 32'h4);

    // memory not ready: the fetch address must hold until accepted
    lat = 1;
    do_reset(2);
    imem_req_ready_i = 1'b0;
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    check_req("stall.c0", 1'b1, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    check_req("stall.c1", 1'b1, 32'h0);
    check_id("stall.c1", 1'b0, 32'h0);
    imem_req_ready_i = 1'b1;
    #1;
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    check_req("stall.acc", 1'b1, 32'h4);
    wait_valid("stall", n);
    check_id("stall.first", 1'b1, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    check_id("stall.second", 1'b1, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
